// File: rtl/bcd_timer_chain.sv
// bcd_timer_chain: BCD digit chain with per-digit modulus and an IDLE/RUN/DONE control FSM.
// It counts down from a loaded target, or up to it, on qualified ticks.
// Ports:
//   clk, reset (async, active-high)
//   tick, main_enable: count strobe and its qualifier
//   load, start, stop, up_mode: control inputs
//   prog: packed BCD target
//   count: packed BCD time
//   running, expired: status
//   done_pulse: one-cycle terminal strobe
// Build option: define TIMER_AUTORELOAD_EN to make the chain reload on terminal instead of stopping.
module bcd_timer_chain #(
    parameter int                      NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX  = 16'h5959
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    main_enable,
    input  logic                    load,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    up_mode,
    input  logic [4*NUM_DIGITS-1:0] prog,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    running,
    output logic                    done_pulse,
    output logic                    expired
);

    localparam int W = 4 * NUM_DIGITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] target;
    logic         mode;

    logic [W-1:0] prog_clamped;
    logic [W-1:0] count_step;
    logic [W-1:0] terminal;
    logic [W-1:0] load_val;
    logic         at_term;
    logic         step_term;
    logic         chain;
    logic [3:0]   dig;
    logic [3:0]   dmax;

    // Digits above their modulus are pulled down to it.
    always_comb begin
        prog_clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (prog[4*i +: 4] > DIGIT_MAX[4*i +: 4])
                prog_clamped[4*i +: 4] = DIGIT_MAX[4*i +: 4];
            else
                prog_clamped[4*i +: 4] = prog[4*i +: 4];
        end
    end

    // Ripple borrow (down) or carry (up) through the digits.
    // A digit steps only while every lower digit sits at its wrap point.
    always_comb begin
        count_step = count;
        chain      = 1'b1;
        dig        = 4'd0;
        dmax       = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig  = count[4*i +: 4];
            dmax = DIGIT_MAX[4*i +: 4];
            if (chain) begin
                if (mode)
                    count_step[4*i +: 4] = (dig == dmax) ? 4'd0 : dig + 4'd1;
                else
                    count_step[4*i +: 4] = (dig == 4'd0) ? dmax : dig - 4'd1;
            end
            chain = chain & (mode ? (dig == dmax) : (dig == 4'd0));
        end
    end

    assign terminal  = mode ? target : '0;
    assign at_term   = (count == terminal);
    assign step_term = (count_step == terminal);
    assign load_val  = up_mode ? '0 : prog_clamped;

`ifdef TIMER_AUTORELOAD_EN
    logic [W-1:0] reload_val;
    assign reload_val = mode ? '0 : target;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            target     <= '0;
            mode       <= 1'b0;
            count      <= '0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (load) begin
                target <= prog_clamped;
                mode   <= up_mode;
                count  <= load_val;
                state  <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        // A tick arriving with start is not counted.
                        if (start && !at_term)
                            state <= RUN;
                    end
                    RUN: begin
                        if (stop) begin
                            state <= IDLE;
                        end else if (tick && main_enable) begin
`ifdef TIMER_AUTORELOAD_EN
                            if (at_term) begin
                                count <= reload_val;
                            end else begin
                                count <= count_step;
                                if (step_term)
                                    done_pulse <= 1'b1;
                            end
`else
                            count <= count_step;
                            if (step_term) begin
                                state      <= DONE;
                                done_pulse <= 1'b1;
                            end
`endif
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign running = (state == RUN);
    assign expired = (state == DONE);

endmodule

// File: tb/tb_bcd_timer_chain.sv
// tb_bcd_timer_chain: directed scoreboard bench for bcd_timer_chain (default mm:ss build).
// Stimulus queues hand-computed expectations; a negedge monitor pops and compares them.
module tb_bcd_timer_chain;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        main_enable;
    logic        load;
    logic        start;
    logic        stop;
    logic        up_mode;
    logic [15:0] prog;
    logic [15:0] count;
    logic        running;
    logic        done_pulse;
    logic        expired;

    bcd_timer_chain dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .main_enable(main_enable),
        .load       (load),
        .start      (start),
        .stop       (stop),
        .up_mode    (up_mode),
        .prog       (prog),
        .count      (count),
        .running    (running),
        .done_pulse (done_pulse),
        .expired    (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] cnt;
        logic        run;
        logic        exp;
        logic        dp;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   vectors;
    int   miscompares;

    initial begin
        vectors     = 0;
        miscompares = 0;
    end

    always @(negedge clk) begin
        if (q.size() != 0) begin
            cur = q.pop_front();
            vectors++;
            if (count !== cur.cnt || running !== cur.run ||
                expired !== cur.exp || done_pulse !== cur.dp) begin
                miscompares++;
                $display("FAIL %s: got count=%h running=%b expired=%b done=%b, want count=%h running=%b expired=%b done=%b",
                         cur.name, count, running, expired, done_pulse,
                         cur.cnt, cur.run, cur.exp, cur.dp);
            end
        end
    end

    task automatic expect_v(input string n, input logic [15:0] c,
                            input logic r, input logic e, input logic d);
        exp_t v;
        v.name = n;
        v.cnt  = c;
        v.run  = r;
        v.exp  = e;
        v.dp   = d;
        q.push_back(v);
    endtask

    // Apply one cycle of inputs, then return pulses to idle just after the edge.
    task automatic drive(input logic ld, input logic st, input logic sp,
                         input logic tk, input logic en, input logic up,
                         input logic [15:0] pg);
        load        = ld;
        start       = st;
        stop        = sp;
        tick        = tk;
        main_enable = en;
        up_mode     = up;
        prog        = pg;
        @(posedge clk);
        #1;
        load        = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        tick        = 1'b0;
        main_enable = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        tick        = 1'b0;
        main_enable = 1'b1;
        load        = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        up_mode     = 1'b0;
        prog        = 16'h0000;
        #3;
        expect_v("reset", 16'h0000, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef TIMER_AUTORELOAD_EN
        drive(1, 0, 0, 0, 1, 0, 16'h0003);
        expect_v("ar_load", 16'h0003, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 16'h0003);
        expect_v("ar_start", 16'h0003, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0003);
        expect_v("ar_t1", 16'h0002, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0003);
        expect_v("ar_t2", 16'h0001, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0003);
        expect_v("ar_t3", 16'h0000, 1, 0, 1);
        drive(0, 0, 0, 1, 1, 0, 16'h0003);
        expect_v("ar_t4", 16'h0003, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0003);
        expect_v("ar_t5", 16'h0002, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0003);
        expect_v("ar_t6", 16'h0001, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0003);
        expect_v("ar_t7", 16'h0000, 1, 0, 1);
        drive(0, 0, 0, 1, 1, 0, 16'h0003);
        expect_v("ar_t8", 16'h0003, 1, 0, 0);
`else
        // Down count from 01:02 to 00:00.
        drive(1, 0, 0, 0, 1, 0, 16'h0102);
        expect_v("dn_load", 16'h0102, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 16'h0102);
        expect_v("dn_start", 16'h0102, 1, 0, 0);
        for (int k = 1; k <= 62; k++) begin
            drive(0, 0, 0, 1, 1, 0, 16'h0102);
            if (k == 2)  expect_v("dn_t2", 16'h0100, 1, 0, 0);
            if (k == 3)  expect_v("dn_t3", 16'h0059, 1, 0, 0);
            if (k == 32) expect_v("dn_t32", 16'h0030, 1, 0, 0);
            if (k == 61) expect_v("dn_t61", 16'h0001, 1, 0, 0);
            if (k == 62) expect_v("dn_t62", 16'h0000, 0, 1, 1);
        end
        drive(0, 0, 0, 0, 1, 0, 16'h0102);
        expect_v("dn_pulse_end", 16'h0000, 0, 1, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0102);
        expect_v("dn_done_tick", 16'h0000, 0, 1, 0);
        drive(0, 1, 0, 1, 1, 0, 16'h0102);
        expect_v("dn_done_start", 16'h0000, 0, 1, 0);

        // Clamp, then a zero target that cannot start.
        drive(1, 0, 0, 0, 1, 0, 16'h0A7F);
        expect_v("clamp", 16'h0959, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 16'h0000);
        expect_v("zero_load", 16'h0000, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 16'h0000);
        expect_v("zero_start", 16'h0000, 0, 0, 0);

        // Up count to 00:10.
        drive(1, 0, 0, 0, 1, 1, 16'h0010);
        expect_v("up_load", 16'h0000, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 1, 16'h0010);
        expect_v("up_start", 16'h0000, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 0, 1, 1, 1, 16'h0010);
            if (k == 1)  expect_v("up_t1", 16'h0001, 1, 0, 0);
            if (k == 9)  expect_v("up_t9", 16'h0009, 1, 0, 0);
            if (k == 10) expect_v("up_t10", 16'h0010, 0, 1, 1);
        end
        drive(0, 0, 0, 0, 1, 1, 16'h0010);
        expect_v("up_pulse_end", 16'h0010, 0, 1, 0);

        // Up count across the seconds-to-minutes carry.
        drive(1, 0, 0, 0, 1, 1, 16'h0100);
        expect_v("upm_load", 16'h0000, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 1, 16'h0100);
        expect_v("upm_start", 16'h0000, 1, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            drive(0, 0, 0, 1, 1, 1, 16'h0100);
            if (k == 59) expect_v("upm_t59", 16'h0059, 1, 0, 0);
            if (k == 60) expect_v("upm_t60", 16'h0100, 0, 1, 1);
        end

        // Pause, stop/resume and priority.
        drive(1, 0, 0, 0, 1, 0, 16'h0030);
        expect_v("ps_load", 16'h0030, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 16'h0030);
        expect_v("ps_start", 16'h0030, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 0, 0, 16'h0030);
            expect_v("ps_disabled", 16'h0030, 1, 0, 0);
        end
        drive(0, 0, 0, 1, 1, 0, 16'h0030);
        expect_v("ps_tick", 16'h0029, 1, 0, 0);
        drive(0, 0, 1, 1, 1, 0, 16'h0030);
        expect_v("ps_stop_tick", 16'h0029, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0030);
        expect_v("ps_idle_tick", 16'h0029, 0, 0, 0);
        drive(0, 1, 0, 1, 1, 0, 16'h0030);
        expect_v("ps_start_tick", 16'h0029, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 16'h0030);
        expect_v("ps_resume", 16'h0028, 1, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 16'h0015);
        expect_v("ps_load_tick", 16'h0015, 0, 0, 0);

        // Asynchronous reset mid-run at 00:30.
        drive(1, 0, 0, 0, 1, 0, 16'h0031);
        drive(0, 1, 0, 0, 1, 0, 16'h0031);
        drive(0, 0, 0, 1, 1, 0, 16'h0031);
        expect_v("rst_pre", 16'h0030, 1, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        expect_v("rst_mid", 16'h0000, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1, 0, 0, 1, 0, 16'h0000);
        expect_v("rst_after_start", 16'h0000, 0, 0, 0);
`endif

        for (int w = 0; w < 10 && q.size() != 0; w++)
            @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
